// File: rtl/ghost_move_scheduler_pkg.sv
// Shared encodings for the ghost movement scheduler: directions, FSM states
// and default spawn constants.
package ghost_move_scheduler_pkg;

    localparam logic [2:0] DIR_STAY  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_REQ    = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_SPAWN_X  = 27;
    localparam int DEF_SPAWN_DX = 2;
    localparam int DEF_SPAWN_Y  = 24;

    function automatic logic [2:0] dir_of(input logic [7:0] rnd);
        return 3'(rnd % 8'd5);
    endfunction

endpackage

// File: rtl/ghost_move_scheduler_tick_divider.sv
// Free-running movement tick generator; freezes while enable is low.
// Shared with the pacman controller.
module tick_divider #(
    parameter int TICK_DIV = 833333
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = enable && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ghost_move_scheduler.sv
// Walks every ghost once per movement tick through a single shared
// wall-lookup port, committing or rejecting one random step per ghost.
module ghost_move_scheduler
    import ghost_move_scheduler_pkg::*;
#(
    parameter int NUM_GHOSTS = 4,
    parameter int TICK_DIV   = 833333,
    parameter int SPAWN_X    = DEF_SPAWN_X,
    parameter int SPAWN_DX   = DEF_SPAWN_DX,
    parameter int SPAWN_Y    = DEF_SPAWN_Y,
    parameter int X_MAX      = 159,
    parameter int Y_MAX      = 119
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [7:0]              random_in,
    input  logic [7:0]              pac_x,
    input  logic [7:0]              pac_y,
    output logic                    wall_req,
    output logic [7:0]              wall_x,
    output logic [7:0]              wall_y,
    input  logic                    wall_ack,
    input  logic                    wall_blocked,
    output logic [8*NUM_GHOSTS-1:0] ghost_x_flat,
    output logic [8*NUM_GHOSTS-1:0] ghost_y_flat,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    caught,
    output logic                    overrun
);
    localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [GW-1:0] LAST_G = GW'(NUM_GHOSTS - 1);
    localparam logic [7:0] XMAX8 = 8'(X_MAX);
    localparam logic [7:0] YMAX8 = 8'(Y_MAX);

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic            accept_q, accept_d;
    logic [7:0]      wx_q, wx_d, wy_q, wy_d;
    logic [7:0]      gx_q [NUM_GHOSTS];
    logic [7:0]      gy_q [NUM_GHOSTS];
    logic            tick;
    logic [2:0]      dir;
    logic [7:0]      cur_x, cur_y, nx, ny;
    logic            legal;
    logic            hit;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    // Candidate cell for the current ghost; edge moves are illegal, never wrapped.
    always_comb begin
        dir   = dir_of(random_in);
        cur_x = gx_q[g_q];
        cur_y = gy_q[g_q];
        nx    = cur_x;
        ny    = cur_y;
        legal = 1'b0;
        case (dir)
            DIR_UP:    begin ny = cur_y - 8'd1; legal = (cur_y != 8'd0);  end
            DIR_DOWN:  begin ny = cur_y + 8'd1; legal = (cur_y <  YMAX8); end
            DIR_LEFT:  begin nx = cur_x - 8'd1; legal = (cur_x != 8'd0);  end
            DIR_RIGHT: begin nx = cur_x + 8'd1; legal = (cur_x <  XMAX8); end
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        accept_d = accept_q;
        wx_d     = wx_q;
        wy_d     = wy_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    g_d     = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                accept_d = 1'b0;
                if (legal) begin
                    wx_d    = nx;
                    wy_d    = ny;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_REQ: begin
                if (wall_ack) begin
                    accept_d = !wall_blocked;
                    state_d  = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (g_q == LAST_G) begin
                    state_d = ST_DONE;
                end else begin
                    g_d     = g_q + GW'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            g_q      <= '0;
            accept_q <= 1'b0;
            wx_q     <= '0;
            wy_q     <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            accept_q <= accept_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int g = 0; g < NUM_GHOSTS; g++) begin
                gx_q[g] <= 8'(SPAWN_X + g * SPAWN_DX);
                gy_q[g] <= 8'(SPAWN_Y);
            end
        end else if (state_q == ST_COMMIT && accept_q) begin
            gx_q[g_q] <= wx_q;
            gy_q[g_q] <= wy_q;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int g = 0; g < NUM_GHOSTS; g++) begin
            if (gx_q[g] == pac_x && gy_q[g] == pac_y) hit = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_flat
        assign ghost_x_flat[8*g +: 8] = gx_q[g];
        assign ghost_y_flat[8*g +: 8] = gy_q[g];
    end

    assign wall_req   = (state_q == ST_REQ);
    assign wall_x     = wx_q;
    assign wall_y     = wy_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign caught     = (state_q == ST_DONE) && hit;
    assign overrun    = tick && (state_q != ST_IDLE);

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Directed bench: two scheduler instances (default spawn, and all ghosts at x=0)
// driven with hand-computed expectations and a 2-cycle wall-lookup responder.
module tb_ghost_move_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [7:0]  random_in, random_b;
    logic [7:0]  pac_x, pac_y;
    logic        wall_req, wall_ack, wall_blocked;
    logic [7:0]  wall_x, wall_y;
    logic [31:0] gxf, gyf;
    logic        busy, frame_done, caught, overrun;

    logic        wall_req_b, busy_b, frame_done_b, caught_b, overrun_b;
    logic [7:0]  wall_x_b, wall_y_b;
    logic [31:0] gxf_b, gyf_b;
    logic        wall_ack_b = 1'b0;
    logic        wall_blocked_b = 1'b0;

    int n_chk = 0, n_fail = 0;
    int fd_cnt = 0, caught_cnt = 0, caught_err = 0, ov_cnt = 0, reqb_cnt = 0;
    int hs_cnt = 0, stable_err = 0, req_cyc = 0;
    bit ack_hold = 1'b0;
    logic [7:0] held_x, held_y;
    logic [7:0] ack_x [$];

    always #5 clk = ~clk;

    ghost_move_scheduler #(.NUM_GHOSTS(4), .TICK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .random_in(random_in),
        .pac_x(pac_x), .pac_y(pac_y), .wall_req(wall_req), .wall_x(wall_x),
        .wall_y(wall_y), .wall_ack(wall_ack), .wall_blocked(wall_blocked),
        .ghost_x_flat(gxf), .ghost_y_flat(gyf), .busy(busy),
        .frame_done(frame_done), .caught(caught), .overrun(overrun)
    );

    ghost_move_scheduler #(.NUM_GHOSTS(4), .TICK_DIV(4), .SPAWN_X(0), .SPAWN_DX(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .random_in(random_b),
        .pac_x(pac_x), .pac_y(pac_y), .wall_req(wall_req_b), .wall_x(wall_x_b),
        .wall_y(wall_y_b), .wall_ack(wall_ack_b), .wall_blocked(wall_blocked_b),
        .ghost_x_flat(gxf_b), .ghost_y_flat(gyf_b), .busy(busy_b),
        .frame_done(frame_done_b), .caught(caught_b), .overrun(overrun_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Wall responder: ack on the second low phase of a request, candidate must stay put.
    initial begin
        wall_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!wall_req) begin
                wall_ack = 1'b0;
                req_cyc  = 0;
            end else begin
                if (req_cyc == 0) begin
                    held_x = wall_x;
                    held_y = wall_y;
                end else if (wall_x !== held_x || wall_y !== held_y) begin
                    stable_err++;
                end
                req_cyc++;
                if (req_cyc >= 2 && !ack_hold && !wall_ack) begin
                    wall_ack = 1'b1;
                    hs_cnt++;
                    ack_x.push_back(wall_x);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (caught) caught_cnt++;
            if (caught && !frame_done) caught_err++;
            if (overrun) ov_cnt++;
            if (wall_req_b) reqb_cnt++;
        end
    end

    task automatic do_tick();
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (fd_cnt <= base && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (fd_cnt <= base) chk("done_timeout", fd_cnt, base + 1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!wall_req && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("req_seen", int'(wall_req), 1);
    endtask

    task automatic check_pos(input string tag, input int x0, input int dx, input int y);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_g%0d_x", tag, i), int'(gxf[8*i +: 8]), x0 + i * dx);
            chk($sformatf("%s_g%0d_y", tag, i), int'(gyf[8*i +: 8]), y);
        end
    endtask

    initial begin
        int fd0, hs0, ov0;
        reset_n = 1'b0; enable = 1'b0; random_in = 8'd4; random_b = 8'd3;
        pac_x = 8'd28; pac_y = 8'd24; wall_blocked = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_pos("rst", 27, 2, 24);
        chk("rst_wall_req", int'(wall_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_wall_x", int'(wall_x), 0);
        chk("rst_b_x0", int'(gxf_b[7:0]), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Pass 1: every ghost steps right, ghost 0 lands on pacman.
        do_tick();
        wait_done(0);
        repeat (5) @(negedge clk);
        #1;
        check_pos("p1", 28, 2, 24);
        chk("p1_frame_done_cnt", fd_cnt, 1);
        chk("p1_handshakes", hs_cnt, 4);
        chk("p1_wall_x0", int'(ack_x[0]), 28);
        chk("p1_wall_x3", int'(ack_x[3]), 34);
        chk("p1_stable", stable_err, 0);
        chk("p1_caught_cnt", caught_cnt, 1);
        chk("p1_caught_align", caught_err, 0);
        chk("p1_busy", int'(busy), 0);
        chk("b_no_req_left", reqb_cnt, 0);
        chk("b_x_stays", int'(gxf_b[31:24]), 0);

        // Pass 2: every candidate is a wall.
        wall_blocked = 1'b1; pac_x = 8'd0; pac_y = 8'd0;
        do_tick();
        wait_done(1);
        repeat (3) @(negedge clk);
        #1;
        check_pos("blk", 28, 2, 24);
        chk("blk_handshakes", hs_cnt, 8);
        chk("blk_caught_cnt", caught_cnt, 1);

        // Pass 3: dir stay on both instances.
        random_in = 8'd0; random_b = 8'd0; wall_blocked = 1'b0;
        do_tick();
        wait_done(2);
        repeat (3) @(negedge clk);
        #1;
        check_pos("stay", 28, 2, 24);
        chk("stay_handshakes", hs_cnt, 8);
        chk("b_no_req_stay", reqb_cnt, 0);
        chk("b_x_stay", int'(gxf_b[7:0]), 0);

        // Stall the lookup across a second tick.
        random_in = 8'd4; random_b = 8'd3; ack_hold = 1'b1;
        ov0 = ov_cnt; fd0 = fd_cnt;
        do_tick();
        wait_req();
        do_tick();
        #1;
        chk("ovr_pulse", ov_cnt - ov0, 1);
        chk("ovr_busy", int'(busy), 1);
        chk("ovr_still_req", int'(wall_req), 1);
        ack_hold = 1'b0;
        wait_done(fd0);
        repeat (20) @(negedge clk);
        #1;
        chk("ovr_one_frame", fd_cnt - fd0, 1);
        check_pos("ovr", 29, 2, 24);

        // Reset in the middle of a lookup.
        ack_hold = 1'b1;
        hs0 = hs_cnt;
        do_tick();
        wait_req();
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_wall_req", int'(wall_req), 0);
        chk("mid_rst_busy", int'(busy), 0);
        check_pos("mid_rst", 27, 2, 24);
        @(negedge clk);
        reset_n = 1'b1;
        ack_hold = 1'b0;
        fd0 = fd_cnt;
        repeat (10) @(negedge clk);
        #1;
        chk("mid_rst_no_frame", fd_cnt - fd0, 0);
        chk("mid_rst_no_ack", hs_cnt - hs0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ghost_move_scheduler.md
Name: ghost_move_scheduler

Overview:
- Time-multiplexes one movement/wall-check path across NUM_GHOSTS ghosts.
- Uses a single external maze wall-lookup port (req/ack handshake).
- Each frame tick it walks ghosts 0..NUM_GHOSTS-1 in order, draws a random direction per ghost, checks the target cell and commits or rejects the move.
- Owns all ghost position registers; feeds the renderer and the game-state logic (pacman collision).

Parameters:
- NUM_GHOSTS, 4, number of ghosts scheduled (1..8).
- TICK_DIV, 833333, clk cycles per movement tick (60 Hz at 50 MHz).
- SPAWN_X, 27, reset x of ghost 0.
- SPAWN_DX, 2, x spacing between consecutive ghost spawns.
- SPAWN_Y, 24, reset y of all ghosts.
- X_MAX, 159, largest legal x.
- Y_MAX, 119, largest legal y.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- enable  in  1  1 = game running; 0 freezes tick counter
- random_in  in  8  LFSR value, sampled once per ghost
- pac_x  in  8  pacman x
- pac_y  in  8  pacman y
- wall_req  out  1  wall lookup request
- wall_x  out  8  candidate x under lookup
- wall_y  out  8  candidate y under lookup
- wall_ack  in  1  lookup result valid (sampled only while wall_req=1)
- wall_blocked  in  1  1 = candidate cell is wall, valid with wall_ack
- ghost_x_flat  out  8*NUM_GHOSTS  ghost g x at [8g+7:8g]
- ghost_y_flat  out  8*NUM_GHOSTS  ghost g y at [8g+7:8g]
- busy  out  1  pass in progress
- frame_done  out  1  1-cycle pulse at end of pass
- caught  out  1  1-cycle pulse, coincident with frame_done, if any ghost equals (pac_x,pac_y)
- overrun  out  1  1-cycle pulse when a tick arrives while busy

Behaviour:
- Reset values (reset_n=0 at a rising clk edge):
  - ghost g = (SPAWN_X+g*SPAWN_DX, SPAWN_Y).
  - wall_req, busy, frame_done, caught, overrun = 0.
  - wall_x/wall_y = 0; tick counter = 0; FSM in IDLE.
- Reset mid-pass: aborts immediately; wall_req low next cycle; an outstanding ack is ignored.
- Tick counter:
  - Increments when enable=1 and holds when enable=0.
  - At TICK_DIV-1 it wraps to 0 and raises tick for 1 cycle.
- Direction: dir = random_in % 5 (0 stay, 1 up y-1, 2 down y+1, 3 left x-1, 4 right x+1).
- FSM states: IDLE, LOAD, REQ, COMMIT, DONE.
  - IDLE: on tick -> g=0, busy=1, go to LOAD.
  - LOAD (1 cycle): sample dir, compute candidate. Next state by case:
    - dir=0 -> COMMIT, no change.
    - Candidate outside 0..X_MAX / 0..Y_MAX (x=0 left, y=0 up, x=X_MAX right, y=Y_MAX down) -> COMMIT, rejected, no request.
    - Otherwise -> REQ.
  - REQ: wall_req=1; wall_x/wall_y hold the candidate, stable until ack.
    - Ack may arrive in the first REQ cycle; with no ack, REQ waits indefinitely (no timeout).
    - On wall_ack=1 -> COMMIT; wall_req drops the following cycle.
    - Accept the move iff wall_blocked=0.
  - COMMIT (1 cycle): write ghost g if accepted.
    - If g=NUM_GHOSTS-1 -> DONE; else g++ -> LOAD.
  - DONE (1 cycle): frame_done=1; caught=1 iff any updated ghost position equals pac; busy=0 next cycle; -> IDLE.
- Latency per ghost: 2 cycles (stay/rejected), else 2 + ack wait + 1.
- A tick seen outside IDLE is dropped and pulses overrun the same cycle; passes never queue.
- No arithmetic wrap: boundary moves are rejected, never wrapped.
- Simultaneous tick and DONE: tick dropped, overrun pulses.
- Position outputs change only in COMMIT, one ghost per cycle.

Decomposition:
- Shared include ghost_defs.vh holds:
  - DIR_STAY/UP/DOWN/LEFT/RIGHT encodings (3-bit);
  - FSM state encodings;
  - default spawn constants.
- One sub-module, tick_divider (parameter TICK_DIV; inputs clk, reset_n, enable; output tick). It is reused by the pacman controller.

Test Plan:
- Reset, NUM_GHOSTS=4: positions (27,24),(29,24),(31,24),(33,24); wall_req=0, busy=0.
- TICK_DIV=4, random_in=4, ack 2 cycles after req, blocked=0 -> ghost0 goes to (28,24). wall_x=28/wall_y=24 stable during req. frame_done pulses once after ghost 3 commits.
- Same stimulus with wall_blocked=1 -> all ghosts unchanged; 4 handshakes observed.
- SPAWN_X=0, SPAWN_DX=0, random_in=3 -> no wall_req in the pass; x stays 0. Then random_in=0 -> no req, positions unchanged.
- Hold wall_ack=0 across the next tick -> overrun pulses, busy stays 1. Release ack -> exactly one frame_done.
- pac=(28,24) with the ghost0-right-move stimulus -> caught pulses with frame_done. Separately, reset_n=0 during REQ -> wall_req=0 next cycle and spawn positions restored.
